// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester lanes plus the UART TX FIFO write port.
// The arbiter uses the master modport; the packet sources and FIFO use the slave one.
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 2
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   req_ready;
    logic               tx_full;
    logic [7:0]         w_data;
    logic               wr_uart;
    logic [IW-1:0]      grant_id;
    logic               busy;
    logic               err_timeout;

    modport master (
        input  req_valid, req_data, req_last, tx_full,
        output req_ready, w_data, wr_uart, grant_id, busy, err_timeout
    );

    modport slave (
        output req_valid, req_data, req_last, tx_full,
        input  req_ready, w_data, wr_uart, grant_id, busy, err_timeout
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, whole-packet sharing of the UART TX FIFO
// write port, paced by tx_full, with abort of packets that stall too long.
module uart_tx_arbiter #(
    parameter int N_REQ   = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    uart_tx_arbiter_if.master bus
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic {IDLE, SEND} state_t;

    state_t          r_state;
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   r_g;
    logic [TW-1:0]   r_tcnt;
    logic [7:0]      r_w_data;
    logic            r_wr_uart;
    logic            r_err;

    logic            w_win;
    logic [IW-1:0]   w_win_idx;
    logic [IW-1:0]   w_gnext;
    logic            w_gvalid;
    logic            w_glast;
    logic [7:0]      w_gdata;
    logic            w_rdy_g;
    logic            w_hs;
    logic [N_REQ-1:0] w_ready;

    // Rotating priority scan from r_ptr; lower offsets overwrite, so the first set bit wins
    always_comb begin
        w_win     = 1'b0;
        w_win_idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            logic [IW-1:0] j;
            j = IW'((int'(r_ptr) + k) % N_REQ);
            if (bus.req_valid[j]) begin
                w_win     = 1'b1;
                w_win_idx = j;
            end
        end
    end

    assign w_gnext  = (r_g == IW'(N_REQ - 1)) ? '0 : r_g + 1'b1;
    assign w_gvalid = bus.req_valid[r_g];
    assign w_glast  = bus.req_last[r_g];
    assign w_gdata  = bus.req_data[int'(r_g)*8 +: 8];

    // Skipping the cycle after each write lets tx_full catch up before the next accept
    assign w_rdy_g  = (r_state == SEND) && !bus.tx_full && !r_wr_uart;
    assign w_hs     = w_rdy_g && w_gvalid;

    // Only the granted lane can see ready
    always_comb begin
        w_ready      = '0;
        w_ready[r_g] = w_rdy_g;
    end

    // Arbitration / send FSM with registered write port and error pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_g       <= '0;
            r_tcnt    <= '0;
            r_w_data  <= 8'h00;
            r_wr_uart <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_wr_uart <= 1'b0;
            r_err     <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_win) begin
                        r_g     <= w_win_idx;
                        r_tcnt  <= '0;
                        r_state <= SEND;
                    end
                end
                SEND: begin
                    if (w_hs) begin
                        r_w_data  <= w_gdata;
                        r_wr_uart <= 1'b1;
                        r_tcnt    <= '0;
                        if (w_glast) begin
                            r_state <= IDLE;
                            r_ptr   <= w_gnext;
                        end
                    end else if (!w_gvalid) begin
                        if (r_tcnt == TW'(TIMEOUT - 1)) begin
                            r_state <= IDLE;
                            r_err   <= 1'b1;
                            r_ptr   <= w_gnext;
                            r_tcnt  <= '0;
                        end else begin
                            r_tcnt <= r_tcnt + 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready   = w_ready;
    assign bus.w_data      = r_w_data;
    assign bus.wr_uart     = r_wr_uart;
    assign bus.grant_id    = r_g;
    assign bus.busy        = (r_state == SEND);
    assign bus.err_timeout = r_err;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenarios for the UART TX arbiter,
// two requesters with a 16-cycle stall timeout.
module tb_uart_tx_arbiter;
    localparam int N  = 2;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.N_REQ(N)) bus ();

    uart_tx_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_run  = 0;
    int n_fail = 0;
    int cyc_n  = 0;
    int adj    = 0;
    int n_err  = 0;
    bit prev_wr = 1'b0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    bit         l0[$];
    bit         l1[$];
    logic [7:0] wq[$];
    int         gq[$];

    // Present queue heads on the requester lanes
    task automatic drive();
        bus.req_valid[0]   = (q0.size() > 0);
        bus.req_data[7:0]  = (q0.size() > 0) ? q0[0] : 8'h00;
        bus.req_last[0]    = (q0.size() > 0) ? l0[0] : 1'b0;
        bus.req_valid[1]   = (q1.size() > 0);
        bus.req_data[15:8] = (q1.size() > 0) ? q1[0] : 8'h00;
        bus.req_last[1]    = (q1.size() > 0) ? l1[0] : 1'b0;
    endtask

    // One clock: note handshakes before the edge, pop them after, log writes
    task automatic cyc();
        bit h0;
        bit h1;
        #2;
        h0 = bus.req_valid[0] && bus.req_ready[0];
        h1 = bus.req_valid[1] && bus.req_ready[1];
        @(posedge clk);
        #1;
        cyc_n++;
        if (h0) begin
            void'(q0.pop_front());
            void'(l0.pop_front());
        end
        if (h1) begin
            void'(q1.pop_front());
            void'(l1.pop_front());
        end
        drive();
        if (bus.wr_uart) begin
            wq.push_back(bus.w_data);
            gq.push_back(int'(bus.grant_id));
            if (prev_wr) adj++;
        end
        prev_wr = bus.wr_uart;
        if (bus.err_timeout) n_err++;
    endtask

    task automatic wait_writes(input int n, input int bound, input string nm);
        int k = 0;
        while (wq.size() < n && k < bound) begin
            cyc();
            k++;
        end
        n_run++;
        if (wq.size() < n) begin
            n_fail++;
            $display("FAIL %s: got %0d writes, want %0d", nm, wq.size(), n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.tx_full = 1'b0;
        drive();
        repeat (2) @(posedge clk);
        #1;
        n_run++;
        if (bus.busy !== 1'b0 || bus.wr_uart !== 1'b0 || bus.err_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: busy=%b wr=%b err=%b, want 0 0 0",
                     bus.busy, bus.wr_uart, bus.err_timeout);
        end
        n_run++;
        if (bus.w_data !== 8'h00 || bus.grant_id !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_data: w_data=%h grant=%0d, want 00 0",
                     bus.w_data, bus.grant_id);
        end
        n_run++;
        if (bus.req_ready !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_ready: got %b want 00", bus.req_ready);
        end
        rst = 1'b1;
        cyc();
    endtask

    task automatic test_single();
        logic [7:0] ex[3] = '{8'h41, 8'h42, 8'h43};
        int wc[$];
        bit busy_last = 1'b1;
        int s;
        wq.delete();
        gq.delete();
        adj = 0;
        q0 = '{8'h41, 8'h42, 8'h43};
        l0 = '{1'b0, 1'b0, 1'b1};
        drive();
        for (int k = 0; k < 30 && wc.size() < 3; k++) begin
            s = wq.size();
            cyc();
            if (wq.size() > s) begin
                wc.push_back(cyc_n);
                busy_last = bus.busy;
            end
        end
        n_run++;
        if (wq.size() != 3) begin
            n_fail++;
            $display("FAIL single_count: got %0d writes want 3", wq.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_run++;
                if (wq[i] !== ex[i]) begin
                    n_fail++;
                    $display("FAIL single_byte%0d: got %h want %h", i, wq[i], ex[i]);
                end
            end
            n_run++;
            if (wc[1] - wc[0] != 2 || wc[2] - wc[1] != 2) begin
                n_fail++;
                $display("FAIL single_spacing: gaps %0d %0d want 2 2",
                         wc[1] - wc[0], wc[2] - wc[1]);
            end
        end
        n_run++;
        if (busy_last !== 1'b0) begin
            n_fail++;
            $display("FAIL single_busy_fall: busy=%b at last write, want 0", busy_last);
        end
    endtask

    task automatic test_last_only();
        bit busy_w = 1'b1;
        wq.delete();
        gq.delete();
        q1.push_back(8'h7E);
        l1.push_back(1'b1);
        drive();
        for (int k = 0; k < 20 && wq.size() < 1; k++) begin
            cyc();
            if (wq.size() > 0) busy_w = bus.busy;
        end
        repeat (3) cyc();
        n_run++;
        if (wq.size() != 1 || wq[0] !== 8'h7E || gq[0] != 1) begin
            n_fail++;
            $display("FAIL lastonly_write: n=%0d byte=%h grant=%0d want 1 7e 1",
                     wq.size(), (wq.size() > 0) ? wq[0] : 8'hxx,
                     (gq.size() > 0) ? gq[0] : -1);
        end
        n_run++;
        if (busy_w !== 1'b0) begin
            n_fail++;
            $display("FAIL lastonly_idle: busy=%b at write, want 0", busy_w);
        end
        q0.push_back(8'hC0);
        l0.push_back(1'b1);
        q1.push_back(8'hC1);
        l1.push_back(1'b1);
        drive();
        cyc();
        n_run++;
        if (bus.grant_id !== 1'b0 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL lastonly_ptr: grant=%0d busy=%b want 0 1",
                     bus.grant_id, bus.busy);
        end
        wait_writes(3, 40, "lastonly_drain");
        n_run++;
        if (wq.size() != 3 || wq[1] !== 8'hC0 || wq[2] !== 8'hC1) begin
            n_fail++;
            $display("FAIL lastonly_order: got %0d writes, want c0 c1 after 7e", wq.size());
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] eb[8] = '{8'hA0, 8'hA1, 8'hB0, 8'hB1,
                              8'hA0, 8'hA1, 8'hB0, 8'hB1};
        int eg[8] = '{0, 0, 1, 1, 0, 0, 1, 1};
        wq.delete();
        gq.delete();
        adj = 0;
        q0 = '{8'hA0, 8'hA1, 8'hA0, 8'hA1};
        l0 = '{1'b0, 1'b1, 1'b0, 1'b1};
        q1 = '{8'hB0, 8'hB1, 8'hB0, 8'hB1};
        l1 = '{1'b0, 1'b1, 1'b0, 1'b1};
        drive();
        wait_writes(8, 100, "rr_count");
        if (wq.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                n_run++;
                if (wq[i] !== eb[i] || gq[i] != eg[i]) begin
                    n_fail++;
                    $display("FAIL rr_write%0d: got %h/g%0d want %h/g%0d",
                             i, wq[i], gq[i], eb[i], eg[i]);
                end
            end
        end
        n_run++;
        if (adj != 0) begin
            n_fail++;
            $display("FAIL rr_adjacent: got %0d back-to-back writes want 0", adj);
        end
    endtask

    task automatic test_backpressure();
        int e0;
        wq.delete();
        gq.delete();
        q0 = '{8'h11, 8'h12, 8'h13};
        l0 = '{1'b0, 1'b0, 1'b1};
        drive();
        wait_writes(1, 20, "bp_first");
        e0 = n_err;
        bus.tx_full = 1'b1;
        for (int k = 0; k < 20; k++) begin
            cyc();
            n_run++;
            if (bus.req_ready !== 2'b00 || bus.wr_uart !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_stall%0d: ready=%b wr=%b want 00 0",
                         k, bus.req_ready, bus.wr_uart);
            end
        end
        n_run++;
        if (bus.busy !== 1'b1 || bus.grant_id !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_grant_kept: busy=%b grant=%0d want 1 0",
                     bus.busy, bus.grant_id);
        end
        bus.tx_full = 1'b0;
        wait_writes(3, 20, "bp_resume");
        n_run++;
        if (wq.size() != 3 || wq[0] !== 8'h11 || wq[1] !== 8'h12 || wq[2] !== 8'h13) begin
            n_fail++;
            $display("FAIL bp_bytes: got %0d writes, want 11 12 13", wq.size());
        end
        n_run++;
        if (n_err != e0) begin
            n_fail++;
            $display("FAIL bp_no_timeout: got %0d pulses want 0", n_err - e0);
        end
    endtask

    task automatic test_timeout();
        int e0;
        int at = -1;
        bit busy_e = 1'b1;
        int nw = -1;
        wq.delete();
        gq.delete();
        q1.push_back(8'h55);
        l1.push_back(1'b0);
        drive();
        wait_writes(1, 20, "to_first");
        q0.push_back(8'h66);
        l0.push_back(1'b1);
        drive();
        e0 = n_err;
        for (int k = 1; k <= 30 && at < 0; k++) begin
            cyc();
            if (bus.err_timeout) begin
                at = k;
                busy_e = bus.busy;
                nw = wq.size();
            end
        end
        n_run++;
        if (at != 16) begin
            n_fail++;
            $display("FAIL to_delay: pulse %0d cycles after drop, want 16", at);
        end
        n_run++;
        if (busy_e !== 1'b0 || nw != 1 || n_err != e0 + 1) begin
            n_fail++;
            $display("FAIL to_abort: busy=%b writes=%0d pulses=%0d want 0 1 1",
                     busy_e, nw, n_err - e0);
        end
        cyc();
        n_run++;
        if (bus.grant_id !== 1'b0 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL to_regrant: grant=%0d busy=%b want 0 1",
                     bus.grant_id, bus.busy);
        end
        wait_writes(2, 20, "to_next");
        n_run++;
        if (wq.size() != 2 || wq[1] !== 8'h66) begin
            n_fail++;
            $display("FAIL to_next_byte: got %0d writes, want 55 66", wq.size());
        end
    endtask

    task automatic test_async_reset();
        wq.delete();
        gq.delete();
        q0 = '{8'h21, 8'h22, 8'h23};
        l0 = '{1'b0, 1'b0, 1'b1};
        drive();
        wait_writes(1, 20, "ar_first");
        #3;
        rst = 1'b0;
        #1;
        n_run++;
        if (bus.busy !== 1'b0 || bus.wr_uart !== 1'b0 || bus.err_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL ar_flags: busy=%b wr=%b err=%b want 0 0 0",
                     bus.busy, bus.wr_uart, bus.err_timeout);
        end
        n_run++;
        if (bus.w_data !== 8'h00 || bus.grant_id !== 1'b0 || bus.req_ready !== 2'b00) begin
            n_fail++;
            $display("FAIL ar_data: w_data=%h grant=%0d ready=%b want 00 0 00",
                     bus.w_data, bus.grant_id, bus.req_ready);
        end
        q0 = '{8'h77};
        l0 = '{1'b1};
        q1 = '{8'h88};
        l1 = '{1'b1};
        drive();
        @(posedge clk);
        #1;
        rst = 1'b1;
        prev_wr = 1'b0;
        wq.delete();
        gq.delete();
        cyc();
        n_run++;
        if (bus.grant_id !== 1'b0 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL ar_regrant: grant=%0d busy=%b want 0 1",
                     bus.grant_id, bus.busy);
        end
        wait_writes(2, 30, "ar_drain");
        n_run++;
        if (wq.size() != 2 || wq[0] !== 8'h77 || wq[1] !== 8'h88) begin
            n_fail++;
            $display("FAIL ar_order: got %0d writes, want 77 88", wq.size());
        end
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        bus.tx_full   = 1'b0;
        test_reset();
        test_single();
        test_last_only();
        test_round_robin();
        test_backpressure();
        test_timeout();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmit FIFO write port (`w_data`/`wr_uart`) between `N_REQ` byte-stream requesters, such as per-player state packets and debug/status streams. It grants whole packets in round-robin order, holding the grant until the requester's last byte. It paces writes against the FIFO `tx_full` flag, and aborts a stalled packet after a timeout. It sits between the game-logic packet sources and the UART TX FIFO.

## Interface
- `N_REQ`, 2, number of requesters (2..8)
- `TIMEOUT`, 1024, idle cycles inside a packet before abort (>=2)
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-low reset
- `req_valid`  in  N_REQ  requester i has a byte on its data lane
- `req_data`  in  8*N_REQ  byte lanes; lane i = bits [8i+7:8i]
- `req_last`  in  N_REQ  byte on lane i is the last byte of its packet
- `req_ready`  out  N_REQ  byte on lane i is accepted this cycle
- `tx_full`  in  1  UART TX FIFO full
- `w_data`  out  8  byte to TX FIFO, registered
- `wr_uart`  out  1  one-cycle FIFO write strobe, registered
- `grant_id`  out  $clog2(N_REQ)  index of the current/last granted requester
- `busy`  out  1  a packet is in progress (state SEND)
- `err_timeout`  out  1  one-cycle pulse when a packet is aborted

## Operation
- The FSM has two states, IDLE and SEND. Internal state consists of the round-robin pointer `ptr`, the grant register `g`, and the timeout counter `tcnt`.
- **IDLE:**
  - Scan `req_valid` starting at `ptr` and wrapping modulo `N_REQ`. The first set bit wins.
  - On a win, register `g` and `grant_id`, clear `tcnt`, and go to SEND.
  - If no bit is set, stay in IDLE.
  - `req_ready` is all zeros.
- **SEND:**
  - `req_ready[g] = !tx_full && !wr_uart`. All other `req_ready` bits are 0. This rule is combinational from the registered state and `tx_full`.
  - A handshake occurs when `req_valid[g] && req_ready[g]`.
  - On a handshake, the next cycle has `w_data = lane g` and `wr_uart = 1`, and `tcnt` clears.
  - A handshake with `req_last[g]` returns the FSM to IDLE and sets `ptr = (g+1) mod N_REQ`.
  - When `req_valid[g] = 0`, `tcnt` increments. A held `tx_full` does not count toward the timeout.
  - When `tcnt == TIMEOUT-1` and `req_valid[g] = 0`, the packet is aborted: the FSM goes to IDLE, `err_timeout` pulses, and `ptr` advances as for a normal last byte. No write is issued.
- Non-granted requesters are ignored until re-arbitration. Their `req_valid` may stay high indefinitely.
- `wr_uart` is 0 on every cycle without a preceding handshake. `w_data` holds its last written value.
- The `!wr_uart` term in ready limits writes to one every 2 cycles. This guarantees that `tx_full` reflects the previous write before the next acceptance, so the FIFO is never overrun.

## Timing
- Reset values are: state IDLE, `ptr = 0`, `g = 0`, `tcnt = 0`, `w_data = 8'h00`, `wr_uart = 0`, `grant_id = 0`, `busy = 0`, `err_timeout = 0`, `req_ready = 0`.
- Reset is asynchronous. If `rst` asserts mid-packet, the packet is dropped with no further write. After release, arbitration restarts from requester 0.
- Arbitration latency: `req_valid` at cycle 0 in IDLE gives `busy = 1` and `grant_id` at cycle 1. The earliest `req_ready` is also cycle 1.
- Write latency: a handshake at cycle t gives `wr_uart = 1` and `w_data` valid at cycle t+1. `req_ready` is 0 at t+1, and the next handshake is possible at t+2.
- Packet end: a last-byte handshake at cycle k gives IDLE at k+1 and the new grant at k+2. The minimum gap between packets is 1 idle cycle.
- Timeout: once `req_valid[g]` is 0 for `TIMEOUT` consecutive cycles, `err_timeout = 1` and `busy = 0` on the following cycle.
- Simultaneous requests are resolved purely by `ptr`. A requester that re-asserts immediately after its packet waits behind every other pending requester.
- `tx_full` rising during SEND drops `req_ready` in the same cycle. The grant is kept, and `tcnt` is not affected.

## Test plan
- **Single packet:** requester 0 sends 3 bytes 0x41, 0x42, 0x43 with last on 0x43, `tx_full = 0`.
  - Required: `wr_uart` pulses at 3 non-adjacent cycles spaced 2 apart, `w_data` = 0x41, 0x42, 0x43.
  - Required: `busy` falls 1 cycle after the last handshake.
- **Round-robin:** both requesters are continuously valid, each sending 2-byte packets (0xA0/0xA1 and 0xB0/0xB1).
  - Required: FIFO stream A0 A1 B0 B1 A0 A1 ..., with `grant_id` alternating 0, 1, 0, 1.
  - Required: no interleaving of bytes within a packet.
- **Backpressure:** assert `tx_full` for 20 cycles in mid-packet.
  - Required: `req_ready` is 0 and there is no `wr_uart` during those cycles.
  - Required: no `err_timeout` (with `TIMEOUT = 16`), and the packet completes after release with bytes intact.
- **Timeout:** with `TIMEOUT = 16`, requester 1 sends 1 non-last byte, then drops valid.
  - Required: `err_timeout` pulses exactly 16 cycles after the drop and `busy` goes to 0.
  - Required: requester 0 is granted next if it is valid.
- **Async reset mid-packet:** assert `rst` low while `busy = 1`.
  - Required: all outputs at reset values immediately, without waiting for a clock edge.
  - Required: after release, `grant_id = 0` when requesters 0 and 1 both request.
- **Last-only packet:** `req_last` is set on the first byte (0x7E).
  - Required: one write of 0x7E, IDLE on the next cycle, and `ptr` advanced.
